// File: rtl/ex_operand_stage_if.sv
// Decode-to-ALU operand stage bundle: decode handshake, forwarding sources, flush and ALU side.
// The master drives instructions and forwarding data; the slave is the operand stage.
interface ex_operand_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  in_op;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [XLEN-1:0] in_rs1_val;
  logic [XLEN-1:0] in_rs2_val;
  logic [XLEN-1:0] in_imm;
  logic            in_use_imm;
  logic [4:0]      in_rd;
  logic            in_rd_we;

  logic [4:0]      exmem_rd;
  logic [4:0]      memwb_rd;
  logic            exmem_we;
  logic            memwb_we;
  logic [XLEN-1:0] exmem_val;
  logic [XLEN-1:0] memwb_val;
  logic            exmem_is_load;
  logic            flush;

  logic            out_valid;
  logic            out_ready;
  logic [OPW-1:0]  alu_op;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [4:0]      out_rd;
  logic            out_rd_we;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rs1_val, in_rs2_val, in_imm, in_use_imm,
    output in_rd, in_rd_we, exmem_rd, memwb_rd, exmem_we, memwb_we, exmem_val, memwb_val,
    output exmem_is_load, flush, out_ready,
    input  in_ready, out_valid, alu_op, alu_a, alu_b, out_rd, out_rd_we
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rs1_val, in_rs2_val, in_imm, in_use_imm,
    input  in_rd, in_rd_we, exmem_rd, memwb_rd, exmem_we, memwb_we, exmem_val, memwb_val,
    input  exmem_is_load, flush, out_ready,
    output in_ready, out_valid, alu_op, alu_a, alu_b, out_rd, out_rd_we
  );
endinterface

// File: rtl/ex_operand_stage.sv
// Single-entry decode/ALU pipeline register with EX/MEM and MEM/WB operand forwarding,
// load-use bubble insertion and flush.
module ex_operand_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 4
) (
  input logic               clk,
  input logic               rst_n,
  ex_operand_stage_if.slave bus
);

  logic            valid_q, valid_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0] rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d, imm_q, imm_d;
  logic            use_imm_q, use_imm_d, rd_we_q, rd_we_d;

  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic            hazard, fire_in, fire_out;
  logic            load_rs1, load_rs2;

  function automatic logic [XLEN-1:0] forward(
    input logic [4:0]      src,
    input logic [XLEN-1:0] stored,
    input logic            ex_we,
    input logic [4:0]      ex_rd,
    input logic [XLEN-1:0] ex_val,
    input logic            wb_we,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_val
  );
    if (src == 5'd0)                 return '0;
    else if (ex_we && ex_rd == src)  return ex_val;
    else if (wb_we && wb_rd == src)  return wb_val;
    else                             return stored;
  endfunction

  always_comb begin
    fwd_rs1 = forward(rs1_q, rs1_val_q, bus.exmem_we, bus.exmem_rd, bus.exmem_val,
                      bus.memwb_we, bus.memwb_rd, bus.memwb_val);
    fwd_rs2 = forward(rs2_q, rs2_val_q, bus.exmem_we, bus.exmem_rd, bus.exmem_val,
                      bus.memwb_we, bus.memwb_rd, bus.memwb_val);
    // A source that matches an in-flight load has no usable value yet.
    load_rs1 = bus.exmem_is_load && bus.exmem_we && bus.exmem_rd != 5'd0 &&
               bus.exmem_rd == rs1_q;
    load_rs2 = bus.exmem_is_load && bus.exmem_we && bus.exmem_rd != 5'd0 &&
               bus.exmem_rd == rs2_q;
    hazard   = valid_q && (load_rs1 || (!use_imm_q && load_rs2));

    bus.out_valid = valid_q && !hazard && !bus.flush;
    fire_out      = bus.out_valid && bus.out_ready;
    bus.in_ready  = bus.flush || !valid_q || fire_out;
    fire_in       = bus.in_valid && bus.in_ready;

    bus.alu_op    = op_q;
    bus.alu_a     = fwd_rs1;
    bus.alu_b     = use_imm_q ? imm_q : fwd_rs2;
    bus.out_rd    = rd_q;
    bus.out_rd_we = rd_we_q;
  end

  always_comb begin
    valid_d   = valid_q;
    op_d      = op_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    imm_d     = imm_q;
    use_imm_d = use_imm_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;

    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (fire_in) begin
      valid_d   = 1'b1;
      op_d      = bus.in_op;
      rs1_d     = bus.in_rs1;
      rs2_d     = bus.in_rs2;
      rs1_val_d = bus.in_rs1_val;
      rs2_val_d = bus.in_rs2_val;
      imm_d     = bus.in_imm;
      use_imm_d = bus.in_use_imm;
      rd_d      = bus.in_rd;
      rd_we_d   = bus.in_rd_we;
    end else if (fire_out) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Capture forwarded data so it survives the producer retiring during a stall.
      if (rs1_q != 5'd0 && !load_rs1) rs1_val_d = fwd_rs1;
      if (rs2_q != 5'd0 && !load_rs2) rs2_val_d = fwd_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      op_q      <= op_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      imm_q     <= imm_d;
      use_imm_q <= use_imm_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
    end
  end

endmodule
